// File: rtl/rmt_ctrl_pkt_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rmt_ctrl_pkt_pkg
//  Brief    : Header constants, byte offsets and FSM encoding shared by the
//             RMT control-packet transmitter.
//  Revision : 1.0  initial release
// ============================================================================
package rmt_ctrl_pkt_pkg;

    // Ethernet + VLAN
    localparam logic [47:0] C_DST_MAC    = 48'h06_07_08_09_0a_0b;
    localparam logic [47:0] C_SRC_MAC    = 48'h00_01_02_03_04_05;
    localparam logic [15:0] C_VLAN_TPID  = 16'h8100;
    localparam logic [15:0] C_VLAN_TCI   = 16'h000f;
    localparam logic [15:0] C_ETH_TYPE   = 16'h0800;

    // IPv4
    localparam logic [7:0]  C_IP_VER_IHL = 8'h45;
    localparam logic [7:0]  C_IP_TOS     = 8'h00;
    localparam logic [15:0] C_IP_ID      = 16'h0001;
    localparam logic [15:0] C_IP_FRAG    = 16'h0000;
    localparam logic [7:0]  C_IP_TTL     = 8'h40;
    localparam logic [7:0]  C_IP_PROTO   = 8'h11;
    localparam logic [31:0] C_SRC_IP     = 32'h6f6f6f6f;
    localparam logic [31:0] C_DST_IP     = 32'hdededede;

    // UDP
    localparam logic [15:0] C_UDP_SRC    = 16'h04d2;
    localparam logic [15:0] C_UDP_DST    = 16'hf1f2;

    // Lengths / offsets (bytes)
    localparam int C_HDR_BYTES       = 50;  // first payload byte
    localparam int C_IP_LEN_BASE     = 32;  // IP hdr + UDP hdr + control hdr
    localparam int C_UDP_LEN_BASE    = 12;  // UDP hdr + control hdr
    localparam int C_MIN_FRAME_BYTES = 60;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_SEND = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    // Byte-enable mask for the final beat; a zero remainder means a full beat.
    function automatic logic [63:0] last_keep(input logic [5:0] rem);
        return (rem == 6'd0) ? {64{1'b1}} : ((64'd1 << rem) - 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rmt_ctrl_pkt_tx_csum.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ipv4_csum16
//  Brief    : Combinational IPv4 header checksum over ten 16-bit words
//             (checksum field supplied as zero): sum, fold carries, invert.
//  Revision : 1.0  initial release
// ============================================================================
module ipv4_csum16 (
    input  logic [159:0] hdr_words,
    output logic [15:0]  csum
);

    logic [19:0] w_sum;
    logic [16:0] w_fold1;
    logic [15:0] w_fold2;

    // Wide sum of all ten header words; at most 4 carry bits accumulate.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 10; i++) begin
            w_sum = w_sum + {4'b0000, hdr_words[16*i +: 16]};
        end
    end

    // Two end-around folds are enough: after the first, a carry leaves <= 8.
    assign w_fold1 = {1'b0, w_sum[15:0]} + {13'b0, w_sum[19:16]};
    assign w_fold2 = w_fold1[15:0] + {15'b0, w_fold1[16]};
    assign csum    = ~w_fold2;

endmodule
`default_nettype wire

// File: rtl/rmt_ctrl_pkt_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : rmt_ctrl_pkt_tx
//  Brief    : Builds Eth/VLAN/IPv4/UDP RMT control packets from a command
//             handshake and streams them on a 512-bit AXI-Stream master.
//  Revision : 1.0  initial release
// ============================================================================
module rmt_ctrl_pkt_tx
    import rmt_ctrl_pkt_pkg::*;
#(
    parameter int C_M_AXIS_DATA_WIDTH  = 512,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int MAX_PAYLOAD_BYTES    = 128
) (
    input  logic                                clk,
    input  logic                                aresetn,
    input  logic                                cmd_valid,
    output logic                                cmd_ready,
    input  logic [7:0]                          cmd_type,
    input  logic [7:0]                          cmd_mod,
    input  logic [15:0]                         cmd_index,
    input  logic [7:0]                          cmd_len,
    input  logic [8*MAX_PAYLOAD_BYTES-1:0]      cmd_payload,
    output logic                                cmd_err,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,
    output logic                                busy,
    output logic [31:0]                         tx_pkt_cnt
);

    localparam int KEEP_W  = C_M_AXIS_DATA_WIDTH / 8;
    localparam int FRAME_W = 3 * C_M_AXIS_DATA_WIDTH;   // frame never exceeds 3 beats
    localparam int PAY_W   = 8 * MAX_PAYLOAD_BYTES;

    state_t              r_state;
    logic                r_cmd_ready;
    logic                r_cmd_err;
    logic [7:0]          r_type;
    logic [7:0]          r_mod;
    logic [15:0]         r_index;
    logic [7:0]          r_len;
    logic [PAY_W-1:0]    r_payload;
    logic [FRAME_W-1:0]  r_frame;
    logic                r_tvalid;
    logic [KEEP_W-1:0]   r_tkeep;
    logic                r_tlast;
    logic [1:0]          r_beats_left;
    logic [31:0]         r_pkt_cnt;

    logic                w_len_bad;
    logic [15:0]         w_ip_len;
    logic [15:0]         w_udp_len;
    logic [7:0]          w_frame_raw;
    logic [7:0]          w_frame_len;
    logic [1:0]          w_beats;
    logic [KEEP_W-1:0]   w_last_keep;
    logic [15:0]         w_csum;
    logic [159:0]        w_ip_hdr_zero;
    logic [399:0]        w_hdr_be;
    logic [FRAME_W-1:0]  w_frame;

    // Length arithmetic on the captured command (stable through CALC and SEND).
    assign w_len_bad   = {1'b0, cmd_len} > 9'(MAX_PAYLOAD_BYTES);
    assign w_ip_len    = 16'(C_IP_LEN_BASE) + {8'h00, r_len};
    assign w_udp_len   = 16'(C_UDP_LEN_BASE) + {8'h00, r_len};
    assign w_frame_raw = 8'(C_HDR_BYTES) + r_len;
    assign w_frame_len = (w_frame_raw < 8'(C_MIN_FRAME_BYTES)) ? 8'(C_MIN_FRAME_BYTES) : w_frame_raw;
    assign w_beats     = w_frame_len[7:6] + {1'b0, |w_frame_len[5:0]};
    assign w_last_keep = last_keep(w_frame_len[5:0]);

    assign w_ip_hdr_zero = {C_IP_VER_IHL, C_IP_TOS, w_ip_len, C_IP_ID, C_IP_FRAG,
                            C_IP_TTL, C_IP_PROTO, 16'h0000, C_SRC_IP, C_DST_IP};

    ipv4_csum16 u_csum (
        .hdr_words (w_ip_hdr_zero),
        .csum      (w_csum)
    );

    // Header in wire order, first byte in the MSBs; index is little-endian on the wire.
    assign w_hdr_be = {C_DST_MAC, C_SRC_MAC, C_VLAN_TPID, C_VLAN_TCI, C_ETH_TYPE,
                       C_IP_VER_IHL, C_IP_TOS, w_ip_len, C_IP_ID, C_IP_FRAG,
                       C_IP_TTL, C_IP_PROTO, w_csum, C_SRC_IP, C_DST_IP,
                       C_UDP_SRC, C_UDP_DST, w_udp_len, 16'h0000,
                       r_type, r_mod, r_index[7:0], r_index[15:8]};

    // Lay the frame out with byte n at bits [8n+:8]; bytes past the payload stay zero as pad.
    always_comb begin
        w_frame = '0;
        for (int n = 0; n < C_HDR_BYTES; n++) begin
            w_frame[8*n +: 8] = w_hdr_be[8*(C_HDR_BYTES-1-n) +: 8];
        end
        for (int k = 0; k < MAX_PAYLOAD_BYTES; k++) begin
            if (9'(k) < {1'b0, r_len}) begin
                w_frame[8*(C_HDR_BYTES+k) +: 8] = r_payload[8*k +: 8];
            end
        end
    end

    // Control FSM with command capture, frame shift register and packet counter.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_cmd_ready  <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_type       <= '0;
            r_mod        <= '0;
            r_index      <= '0;
            r_len        <= '0;
            r_payload    <= '0;
            r_frame      <= '0;
            r_tvalid     <= 1'b0;
            r_tkeep      <= '0;
            r_tlast      <= 1'b0;
            r_beats_left <= '0;
            r_pkt_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (r_cmd_ready && cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_type      <= cmd_type;
                        r_mod       <= cmd_mod;
                        r_index     <= cmd_index;
                        r_len       <= cmd_len;
                        r_payload   <= cmd_payload;
                        if (w_len_bad) begin
                            r_cmd_err <= 1'b1;
                            r_state   <= S_ERR;
                        end else begin
                            r_state   <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_frame      <= w_frame;
                    r_tvalid     <= 1'b1;
                    r_tlast      <= (w_beats == 2'd1);
                    r_tkeep      <= (w_beats == 2'd1) ? w_last_keep : {KEEP_W{1'b1}};
                    r_beats_left <= w_beats - 2'd1;
                    r_state      <= S_SEND;
                end
                S_SEND: begin
                    if (m_axis_tready) begin
                        if (r_tlast) begin
                            r_tvalid    <= 1'b0;
                            r_tlast     <= 1'b0;
                            r_tkeep     <= '0;
                            r_frame     <= '0;
                            r_pkt_cnt   <= r_pkt_cnt + 32'd1;
                            r_cmd_ready <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_frame      <= r_frame >> C_M_AXIS_DATA_WIDTH;
                            r_beats_left <= r_beats_left - 2'd1;
                            r_tlast      <= (r_beats_left == 2'd1);
                            r_tkeep      <= (r_beats_left == 2'd1) ? w_last_keep : {KEEP_W{1'b1}};
                        end
                    end
                end
                S_ERR: begin
                    r_cmd_err   <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign cmd_err       = r_cmd_err;
    assign m_axis_tdata  = r_frame[C_M_AXIS_DATA_WIDTH-1:0];
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tuser  = '0;
    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tlast  = r_tlast;
    assign busy          = (r_state != S_IDLE);
    assign tx_pkt_cnt    = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rmt_ctrl_pkt_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_rmt_ctrl_pkt_tx
//  Brief    : Scoreboard bench for the RMT control-packet transmitter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rmt_ctrl_pkt_tx;

    logic           clk = 1'b0;
    logic           aresetn = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [7:0]     cmd_type = '0;
    logic [7:0]     cmd_mod = '0;
    logic [15:0]    cmd_index = '0;
    logic [7:0]     cmd_len = '0;
    logic [1023:0]  cmd_payload = '0;
    logic           cmd_err;
    logic [511:0]   m_axis_tdata;
    logic [63:0]    m_axis_tkeep;
    logic [127:0]   m_axis_tuser;
    logic           m_axis_tvalid;
    logic           m_axis_tready = 1'b0;
    logic           m_axis_tlast;
    logic           busy;
    logic [31:0]    tx_pkt_cnt;

    always #5 clk = ~clk;

    rmt_ctrl_pkt_tx #(
        .C_M_AXIS_DATA_WIDTH  (512),
        .C_M_AXIS_TUSER_WIDTH (128),
        .MAX_PAYLOAD_BYTES    (128)
    ) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_type      (cmd_type),
        .cmd_mod       (cmd_mod),
        .cmd_index     (cmd_index),
        .cmd_len       (cmd_len),
        .cmd_payload   (cmd_payload),
        .cmd_err       (cmd_err),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .tx_pkt_cnt    (tx_pkt_cnt)
    );

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
    } beat_t;

    beat_t          exp_q[$];
    int             n_checks = 0;
    int             n_pass   = 0;
    logic [31:0]    exp_cnt  = '0;
    logic [7:0]     rx [192];
    logic [63:0]    rx_last_keep;
    int             rx_beats;
    int             rx_lat;
    logic [1023:0]  pl1;

    // Reference frame builder: byte array in wire order, then packed into beats.
    function automatic void push_expected(input logic [7:0] typ, input logic [7:0] mod,
                                          input logic [15:0] idx, input int len,
                                          input logic [1023:0] pl);
        logic [7:0]  f [192];
        logic [15:0] iplen, udplen, cs;
        logic [31:0] s;
        int          flen, nb;
        beat_t       b;
        for (int i = 0; i < 192; i++) f[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            f[i]   = 8'h06 + 8'(i);
            f[6+i] = 8'(i);
        end
        iplen  = 16'(32 + len);
        udplen = 16'(12 + len);
        f[12] = 8'h81; f[15] = 8'h0f; f[16] = 8'h08;
        f[18] = 8'h45; f[20] = iplen[15:8]; f[21] = iplen[7:0];
        f[23] = 8'h01; f[26] = 8'h40; f[27] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            f[30+i] = 8'h6f;
            f[34+i] = 8'hde;
        end
        f[38] = 8'h04; f[39] = 8'hd2; f[40] = 8'hf1; f[41] = 8'hf2;
        f[42] = udplen[15:8]; f[43] = udplen[7:0];
        f[46] = typ; f[47] = mod; f[48] = idx[7:0]; f[49] = idx[15:8];
        for (int k = 0; k < len; k++) f[50+k] = pl[8*k +: 8];
        s = 32'h0;
        for (int w = 0; w < 10; w++) s = s + {16'h0, f[18+2*w], f[19+2*w]};
        while (s[31:16] != 16'h0) s = {16'h0, s[15:0]} + {16'h0, s[31:16]};
        cs = ~s[15:0];
        f[28] = cs[15:8]; f[29] = cs[7:0];
        flen = (50 + len < 60) ? 60 : 50 + len;
        nb   = (flen + 63) / 64;
        for (int bi = 0; bi < nb; bi++) begin
            for (int j = 0; j < 64; j++) begin
                b.data[8*j +: 8] = f[64*bi + j];
                b.keep[j]        = (64*bi + j < flen);
            end
            b.last = (bi == nb - 1);
            exp_q.push_back(b);
        end
    endfunction

    task automatic send_cmd(input logic [7:0] typ, input logic [7:0] mod, input logic [15:0] idx,
                            input logic [7:0] len, input logic [1023:0] pl);
        int cyc = 0;
        while (cmd_ready !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_wait: cmd_ready=%b after %0d cycles, required 1", cmd_ready, cyc);
        else n_pass++;
        cmd_type = typ; cmd_mod = mod; cmd_index = idx; cmd_len = len; cmd_payload = pl;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_type  = 8'($urandom);
        cmd_mod   = 8'($urandom);
        cmd_index = 16'($urandom);
        cmd_len   = 8'($urandom);
        for (int i = 0; i < 32; i++) cmd_payload[32*i +: 32] = $urandom;
        @(negedge clk);
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL accept_state: tvalid=%b cmd_ready=%b busy=%b, required 0 0 1", m_axis_tvalid, cmd_ready, busy);
        else n_pass++;
    endtask

    // Pull beats off the stream, compare each against the scoreboard head.
    task automatic collect(input bit rnd);
        int          cyc = 0;
        int          rb = 0;
        bit          done = 0;
        bit          stall = 0;
        logic [511:0] sd;
        logic [63:0]  sk;
        logic         sl;
        beat_t        e;
        rx_lat = -1;
        for (int i = 0; i < 192; i++) rx[i] = 8'h00;
        while (!done && cyc < 500) begin
            @(negedge clk);
            if (rx_lat < 0 && m_axis_tvalid === 1'b1) rx_lat = cyc;
            if (stall) begin
                n_checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== sd || m_axis_tkeep !== sk || m_axis_tlast !== sl)
                    $display("FAIL stall_stable: valid=%b keep=%h last=%b, required 1 %h %b", m_axis_tvalid, m_axis_tkeep, m_axis_tlast, sk, sl);
                else n_pass++;
            end
            if (m_axis_tvalid === 1'b1) begin
                n_checks++;
                if (cmd_ready !== 1'b0 || busy !== 1'b1)
                    $display("FAIL ready_while_send: cmd_ready=%b busy=%b, required 0 1", cmd_ready, busy);
                else n_pass++;
            end
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
                stall = 0;
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL beat_unexpected: beat %0d keep=%h, required no beat", rb, m_axis_tkeep);
                    done = 1;
                end else begin
                    e = exp_q.pop_front();
                    if (m_axis_tdata !== e.data || m_axis_tkeep !== e.keep || m_axis_tlast !== e.last || m_axis_tuser !== 128'h0)
                        $display("FAIL beat%0d: keep=%h last=%b data=%h, required keep=%h last=%b data=%h",
                                 rb, m_axis_tkeep, m_axis_tlast, m_axis_tdata[255:0], e.keep, e.last, e.data[255:0]);
                    else n_pass++;
                    if (rb < 3) for (int j = 0; j < 64; j++) rx[64*rb + j] = m_axis_tdata[8*j +: 8];
                    rx_last_keep = m_axis_tkeep;
                    rb++;
                    if (e.last) done = 1;
                end
            end else if (m_axis_tvalid === 1'b1) begin
                stall = 1;
                sd = m_axis_tdata; sk = m_axis_tkeep; sl = m_axis_tlast;
            end else begin
                stall = 0;
            end
            cyc++;
        end
        rx_beats = rb;
        if (!done) begin
            n_checks++;
            $display("FAIL frame_timeout: %0d beats seen in %0d cycles, required a last beat", rb, cyc);
        end
    endtask

    task automatic run_frame(input logic [7:0] typ, input logic [7:0] mod, input logic [15:0] idx,
                             input int len, input logic [1023:0] pl, input bit rnd);
        push_expected(typ, mod, idx, len, pl);
        send_cmd(typ, mod, idx, 8'(len), pl);
        collect(rnd);
        exp_cnt = exp_cnt + 32'd1;
        @(negedge clk);
        n_checks++;
        if (tx_pkt_cnt !== exp_cnt || cmd_ready !== 1'b1 || m_axis_tvalid !== 1'b0 || busy !== 1'b0)
            $display("FAIL frame_done: cnt=%0d ready=%b valid=%b busy=%b, required %0d 1 0 0", tx_pkt_cnt, cmd_ready, m_axis_tvalid, busy, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b0 || cmd_err !== 1'b0 || m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 ||
            m_axis_tkeep !== 64'h0 || m_axis_tdata !== 512'h0 || m_axis_tuser !== 128'h0 || busy !== 1'b0 || tx_pkt_cnt !== 32'h0)
            $display("FAIL reset_outputs: ready=%b err=%b valid=%b last=%b keep=%h busy=%b cnt=%0d, required all 0",
                     cmd_ready, cmd_err, m_axis_tvalid, m_axis_tlast, m_axis_tkeep, busy, tx_pkt_cnt);
        else n_pass++;
        aresetn = 1'b1;
        #1;
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL ready_before_clk: cmd_ready=%b, required 0", cmd_ready);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL ready_after_clk: cmd_ready=%b, required 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_len34;
        for (int i = 0; i < 32; i++) pl1[32*i +: 32] = $urandom;
        run_frame(8'h00, 8'h00, 16'h0001, 34, pl1, 1'b0);
        n_checks++;
        if (rx_beats != 2 || rx_lat != 0) $display("FAIL len34_beats: beats=%0d latency=%0d, required 2 0", rx_beats, rx_lat);
        else n_pass++;
        n_checks++;
        if ({rx[20], rx[21]} !== 16'h0042 || {rx[28], rx[29]} !== 16'hde0e || {rx[42], rx[43]} !== 16'h002e)
            $display("FAIL len34_fields: iplen=%h csum=%h udplen=%h, required 0042 de0e 002e", {rx[20], rx[21]}, {rx[28], rx[29]}, {rx[42], rx[43]});
        else n_pass++;
        n_checks++;
        if (rx_last_keep !== 64'h00000000000fffff || tx_pkt_cnt !== 32'd1)
            $display("FAIL len34_keep_cnt: keep=%h cnt=%0d, required 00000000000fffff 1", rx_last_keep, tx_pkt_cnt);
        else n_pass++;
    endtask

    task automatic test_len0;
        logic [1023:0] pl;
        logic [79:0]   pad;
        for (int i = 0; i < 32; i++) pl[32*i +: 32] = $urandom;
        run_frame(8'h5a, 8'h03, 16'hbeef, 0, pl, 1'b0);
        for (int i = 0; i < 10; i++) pad[8*i +: 8] = rx[50+i];
        n_checks++;
        if (rx_beats != 1 || rx_last_keep !== 64'h0fffffffffffffff)
            $display("FAIL len0_beats: beats=%0d keep=%h, required 1 0fffffffffffffff", rx_beats, rx_last_keep);
        else n_pass++;
        n_checks++;
        if ({rx[20], rx[21]} !== 16'h0020 || {rx[28], rx[29]} !== 16'hde30)
            $display("FAIL len0_fields: iplen=%h csum=%h, required 0020 de30", {rx[20], rx[21]}, {rx[28], rx[29]});
        else n_pass++;
        n_checks++;
        if (pad !== 80'h0) $display("FAIL len0_pad: bytes50_59=%h, required 0", pad);
        else n_pass++;
    endtask

    task automatic test_len128;
        logic [1023:0] pl;
        logic [1023:0] got;
        for (int i = 0; i < 32; i++) pl[32*i +: 32] = $urandom;
        run_frame(8'h12, 8'h07, 16'h0304, 128, pl, 1'b0);
        for (int k = 0; k < 128; k++) got[8*k +: 8] = rx[50+k];
        n_checks++;
        if (rx_beats != 3 || rx_last_keep !== 64'h0003ffffffffffff || {rx[20], rx[21]} !== 16'h00a0)
            $display("FAIL len128_shape: beats=%0d keep=%h iplen=%h, required 3 0003ffffffffffff 00a0", rx_beats, rx_last_keep, {rx[20], rx[21]});
        else n_pass++;
        n_checks++;
        if (got !== pl) $display("FAIL len128_payload: got=%h, required %h", got[127:0], pl[127:0]);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        run_frame(8'h00, 8'h00, 16'h0001, 34, pl1, 1'b1);
        m_axis_tready = 1'b0;
        n_checks++;
        if (rx_beats != 2 || {rx[28], rx[29]} !== 16'hde0e)
            $display("FAIL bp_frame: beats=%0d csum=%h, required 2 de0e", rx_beats, {rx[28], rx[29]});
        else n_pass++;
    endtask

    task automatic test_err;
        int vcount = 0;
        send_cmd(8'h01, 8'h02, 16'h0003, 8'd200, '0);
        n_checks++;
        if (cmd_err !== 1'b1) $display("FAIL err_pulse: cmd_err=%b, required 1", cmd_err);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (cmd_err !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL err_end: cmd_err=%b cmd_ready=%b, required 0 1", cmd_err, cmd_ready);
        else n_pass++;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_axis_tvalid !== 1'b0 || cmd_err !== 1'b0) vcount++;
        end
        n_checks++;
        if (vcount != 0 || tx_pkt_cnt !== exp_cnt)
            $display("FAIL err_no_frame: bad_cycles=%0d cnt=%0d, required 0 %0d", vcount, tx_pkt_cnt, exp_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic [1023:0] pl;
        for (int i = 0; i < 32; i++) pl[32*i +: 32] = $urandom;
        push_expected(8'h12, 8'h07, 16'h0304, 128, pl);
        send_cmd(8'h12, 8'h07, 16'h0304, 8'd128, pl);
        m_axis_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tlast !== 1'b0)
            $display("FAIL mid_beat2: valid=%b last=%b, required 1 0", m_axis_tvalid, m_axis_tlast);
        else n_pass++;
        #2;
        aresetn = 1'b0;
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || tx_pkt_cnt !== 32'h0 || cmd_ready !== 1'b0)
            $display("FAIL mid_reset: valid=%b busy=%b cnt=%0d ready=%b, required 0 0 0 0", m_axis_tvalid, busy, tx_pkt_cnt, cmd_ready);
        else n_pass++;
        exp_q.delete();
        exp_cnt = '0;
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);
        run_frame(8'h00, 8'h00, 16'h0001, 34, pl1, 1'b0);
        n_checks++;
        if (tx_pkt_cnt !== 32'd1 || rx_beats != 2) $display("FAIL mid_resend: cnt=%0d beats=%0d, required 1 2", tx_pkt_cnt, rx_beats);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [1023:0] pl;
        for (int i = 0; i < 32; i++) pl[32*i +: 32] = $urandom;
        run_frame(8'hc3, 8'h11, 16'h8001, 77, pl, 1'b0);
        run_frame(8'h3c, 8'h22, 16'h0180, 14, pl, 1'b1);
        m_axis_tready = 1'b0;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL b2b_leftover: queue=%0d, required 0", exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_len34();
        test_len0();
        test_len128();
        test_backpressure();
        test_err();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
